// File: rtl/eq_pkg.sv
// eq_pkg: shared FSM state type and band sizing for the equalizer MAC sequencer.
package eq_pkg;
    localparam int EQ_MAX_BANDS = 16;
    localparam int EQ_BAND_W = $clog2(EQ_MAX_BANDS);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } eq_state_e;
endpackage

// File: rtl/eq_gain_loader.sv
// eq_gain_loader: pairs gain bytes lsb-first into 16-bit words and writes them to the
// gain RAM only while the sequencer is idle, holding at most one word pending.
module eq_gain_loader
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_wr,
    input  logic [7:0]           cfg_byte,
    input  logic                 cfg_addr_rst,
    input  logic                 idle,
    output logic                 gain_we,
    output logic [EQ_BAND_W-1:0] gain_wr_addr,
    output logic [15:0]          gain_wr_data,
    output logic                 cfg_overflow
);
    logic                 phase_q, phase_d;
    logic [7:0]           lsb_q, lsb_d;
    logic                 pend_q, pend_d;
    logic [15:0]          data_q, data_d;
    logic [EQ_BAND_W-1:0] addr_q, addr_d;
    logic                 ovf_q, ovf_d;
    logic                 wr, done, accept;

    always_comb begin
        wr      = cfg_wr && !cfg_addr_rst;
        done    = wr && phase_q;
        gain_we = pend_q && idle;
        // the pending slot frees up in the same cycle it is written out
        accept  = done && (!pend_q || gain_we);
        phase_d = cfg_addr_rst ? 1'b0 : wr ? !phase_q : phase_q;
        lsb_d   = (wr && !phase_q) ? cfg_byte : lsb_q;
        pend_d  = cfg_addr_rst ? 1'b0 : accept ? 1'b1 : gain_we ? 1'b0 : pend_q;
        data_d  = accept ? {cfg_byte, lsb_q} : data_q;
        addr_d  = cfg_addr_rst ? '0
                : gain_we ? ((addr_q == EQ_BAND_W'(NUM_BANDS - 1)) ? '0 : addr_q + 1'b1)
                : addr_q;
        ovf_d   = ovf_q || (done && !accept);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            lsb_q   <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            lsb_q   <= lsb_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gain_wr_addr = addr_q;
    assign gain_wr_data = data_q;
    assign cfg_overflow = ovf_q;
endmodule

// File: rtl/eq_mac_sequencer.sv
// eq_mac_sequencer: steps the band mux / MAC through NUM_BANDS bands per sample.
// Optional macro EQ_SEQ_OVERRUN_CNT_EN enables the saturating overrun counter.
module eq_mac_sequencer
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int MULT_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic                 cfg_wr,
    input  logic [7:0]           cfg_byte,
    input  logic                 cfg_addr_rst,
    output logic [EQ_BAND_W-1:0] band_sel,
    output logic                 mac_ce,
    output logic                 acc_bypass,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 gain_we,
    output logic [EQ_BAND_W-1:0] gain_wr_addr,
    output logic [15:0]          gain_wr_data,
    output logic                 cfg_overflow,
    output logic [7:0]           overrun_cnt
);
    localparam int D = 1 + MULT_LAT;

    eq_state_e            state_q, state_d;
    logic [EQ_BAND_W-1:0] band_q, band_d;
    logic [D-1:0]         first_q, first_d;
    logic [D:0]           last_q, last_d;
    logic                 overrun_q, overrun_d;
    logic                 idle, issue, issue_last, ovr_ev;

    always_comb begin
        idle       = state_q == ST_IDLE;
        issue      = state_q == ST_ISSUE;
        issue_last = issue && band_q == EQ_BAND_W'(NUM_BANDS - 1);
        ovr_ev     = sample_valid && !idle;
        out_valid  = last_q[D];
        acc_bypass = first_q[D-1];
        state_d    = (idle && sample_valid) ? ST_ISSUE
                   : issue_last ? ST_DRAIN
                   : (state_q == ST_DRAIN && out_valid) ? ST_IDLE
                   : state_q;
        band_d     = (issue && !issue_last) ? band_q + 1'b1 : '0;
        // tags ride alongside the band data through the multiplier pipeline
        first_d    = (first_q << 1) | D'(issue && band_q == '0);
        last_d     = (last_q << 1) | (D + 1)'(issue_last);
        overrun_d  = overrun_q || ovr_ev;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            band_q    <= '0;
            first_q   <= '0;
            last_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            band_q    <= band_d;
            first_q   <= first_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    assign band_sel = band_q;
    assign busy     = !idle;
    assign mac_ce   = !idle;
    assign overrun  = overrun_q;

`ifdef EQ_SEQ_OVERRUN_CNT_EN
    logic [7:0] ocnt_q, ocnt_d;
    always_comb ocnt_d = (ovr_ev && ocnt_q != 8'hFF) ? ocnt_q + 1'b1 : ocnt_q;
    always_ff @(posedge clk) ocnt_q <= !reset_n ? 8'h00 : ocnt_d;
    assign overrun_cnt = ocnt_q;
`else
    assign overrun_cnt = 8'h00;
`endif

    eq_gain_loader #(.NUM_BANDS(NUM_BANDS)) u_loader (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_wr       (cfg_wr),
        .cfg_byte     (cfg_byte),
        .cfg_addr_rst (cfg_addr_rst),
        .idle         (idle),
        .gain_we      (gain_we),
        .gain_wr_addr (gain_wr_addr),
        .gain_wr_data (gain_wr_data),
        .cfg_overflow (cfg_overflow)
    );
endmodule

// File: doc/eq_mac_sequencer.md
EQ_MAC_SEQUENCER -- requirements
Module: eq_mac_sequencer

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 4: number of equalizer bands summed per sample (legal 1..16).
REQ-002 SHALL have parameter MULT_LAT, default 3: multiplier pipeline depth in clk cycles.
REQ-003 SHALL have clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have sample_valid  input  1  one-cycle pulse: a new stereo band-filter output set is ready.
REQ-006 SHALL have cfg_wr  input  1  byte strobe from the register interface.
REQ-007 SHALL have cfg_byte  input  8  gain byte; lsb first, then msb.
REQ-008 SHALL have cfg_addr_rst  input  1  clears the gain write address and byte phase.
REQ-009 SHALL have band_sel  output  4  band index driven to the band mux and gain RAM read port.
REQ-010 SHALL have mac_ce  output  1  clock enable for the multipliers and accumulators.
REQ-011 SHALL have acc_bypass  output  1  accumulator load (not add) strobe.
REQ-012 SHALL have out_valid  output  1  one-cycle pulse: the accumulator holds the full band sum.
REQ-013 SHALL have busy  output  1  high while a sample is being sequenced.
REQ-014 SHALL have overrun  output  1  sticky: sample_valid arrived while busy.
REQ-015 SHALL have gain_we, gain_wr_addr[3:0], gain_wr_data[15:0]  outputs: gain RAM write port.
REQ-016 SHALL have cfg_overflow  output  1  sticky: a gain write was dropped.
REQ-017 SHALL have overrun_cnt  output  8  count of overruns (see Configuration).

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-019 IDLE + sample_valid SHALL enter ISSUE next cycle with band_sel=0; busy rises in that same cycle.
REQ-020 ISSUE SHALL increment band_sel each cycle and leave for DRAIN after band NUM_BANDS-1; band_sel returns to 0 in DRAIN and IDLE.
REQ-021 mac_ce SHALL be 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-022 Let D = 1 + MULT_LAT. acc_bypass SHALL pulse exactly D cycles after band 0 is issued.
REQ-023 out_valid SHALL pulse D+1 cycles after band NUM_BANDS-1 is issued. DRAIN SHALL exit to IDLE in the cycle following out_valid.
REQ-024 Latency: sample_valid at cycle 0 SHALL give out_valid at cycle NUM_BANDS+D+1 (9 for the defaults).
REQ-025 Timing of acc_bypass and out_valid SHALL come from a tag shift register D+1 deep, not from a free counter.
REQ-026 sample_valid while busy SHALL be ignored and SHALL set overrun; only reset clears overrun.
REQ-027 Gain loader: the first cfg_wr latches the lsb; the second forms {msb,lsb} and completes the pair; byte phase then toggles back to lsb.
REQ-028 gain_we SHALL be a one-cycle pulse, issued only while the FSM is in IDLE.
REQ-029 A pair completed during IDLE SHALL write in the next cycle.
REQ-030 A pair completed while busy SHALL be held in a one-deep pending register and written on the first IDLE cycle.
REQ-031 A second pair completed while a write is pending SHALL be dropped and SHALL set cfg_overflow (sticky).
REQ-032 gain_wr_addr SHALL increment after every gain_we and wrap from NUM_BANDS-1 to 0.
REQ-033 cfg_addr_rst SHALL zero the address, the byte phase and the pending write. It wins over a simultaneous cfg_wr.
REQ-034 If a pending write and sample_valid meet on the same IDLE cycle, the write SHALL issue and the sample SHALL still start.

Reset
REQ-035 With reset_n=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE, including when asserted mid-sequence.
REQ-036 Reset SHALL clear the tag pipeline, byte phase, pending write, overrun, cfg_overflow and overrun_cnt.

Configuration
REQ-037 With macro EQ_SEQ_OVERRUN_CNT_EN defined, overrun_cnt SHALL count every ignored sample_valid and saturate at 255.
REQ-038 Without EQ_SEQ_OVERRUN_CNT_EN, overrun_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-039 A shared package eq_pkg SHALL hold the FSM state enum, EQ_MAX_BANDS=16 and the band index width.
REQ-040 The gain byte pairing and pending logic SHALL be one sub-module, eq_gain_loader; the FSM and tag pipeline SHALL stay in the top.

Verification
REQ-041 Defaults, sample_valid at cycle 0 -> band_sel 0,1,2,3 on cycles 1-4; acc_bypass at cycle 5; out_valid at cycle 9; busy low at cycle 10.
REQ-042 sample_valid again at cycle 3 -> ignored; overrun=1; overrun_cnt=1 with the macro, 0 without; the next out_valid still at cycle 9.
REQ-043 Write bytes 0x34,0x12 in IDLE -> gain_we with data 0x1234, addr 0; five pairs -> last write at addr 0 (wrap).
REQ-044 Pair completed at cycle 4 of a sequence -> gain_we in the first IDLE cycle after out_valid; a second pair before then -> cfg_overflow=1 and only the first write occurs.
REQ-045 reset_n low at cycle 6 -> all outputs 0 next cycle; a fresh sample_valid afterwards reproduces the REQ-041 timing.
REQ-046 cfg_addr_rst after a single lsb byte -> the next two bytes write to addr 0 with the new lsb.
